// File: rtl/tetris_pkg.sv
// Shared types and constants for the playfield pipeline: state encoding,
// field geometry, spawn origin and the row-collapse helper.
package tetris_pkg;

  localparam int unsigned ROWS  = 20;
  localparam int unsigned COLS  = 10;
  localparam int unsigned ROW_W = 5;
  localparam int unsigned COL_W = 4;
  localparam int unsigned CNT_W = 8;

  localparam logic [COL_W-1:0] SPAWN_X = 4'd3;
  localparam logic [ROW_W-1:0] SPAWN_Y = 5'd0;

  typedef logic [ROWS-1:0][COLS-1:0] field_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SPAWN    = 3'd1,
    SETTLE   = 3'd2,
    FALL     = 3'd3,
    LOCK     = 3'd4,
    CLEAR    = 3'd5,
    GAMEOVER = 3'd6
  } state_e;

  // Remove row r: every row above it moves down one, the top row empties.
  function automatic field_t collapse_row(input field_t f, input logic [ROW_W-1:0] r);
    field_t g;
    g = f;
    for (int i = ROWS - 1; i > 0; i--) begin
      if (ROW_W'(i) <= r) g[i] = g[i-1];
    end
    g[0] = '0;
    return g;
  endfunction

endpackage

// File: rtl/piece_controller.sv
// Falling-piece sequencer: gravity, player moves, locking, row clearing and
// respawn. Optional hard drop is enabled with `define HARD_DROP_EN.
module piece_controller
  import tetris_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               tick_drop,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_down,
  input  logic               btn_hard,
  input  logic               collision_bottom,
  input  logic               collision_left,
  input  logic               collision_right,
  input  field_t             falling_block_display,
  output logic [ROW_W-1:0]   blockY,
  output logic [COL_W-1:0]   blockX,
  output field_t             stored_array,
  output logic               spawn_req,
  output logic [CNT_W-1:0]   lines_cleared,
  output logic               game_over
);

  state_e             state, state_next;
  logic [ROW_W-1:0]   y_next;
  logic [COL_W-1:0]   x_next;
  field_t             field_next;
  logic [CNT_W-1:0]   lines_next;
  logic [ROW_W-1:0]   scan_row, scan_row_next;
  logic               descend_c;

`ifdef HARD_DROP_EN
  logic drop_mode, drop_mode_next;
`else
  logic unused_btn_hard;
  assign unused_btn_hard = btn_hard;
`endif

  assign descend_c = tick_drop | btn_down;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      blockY        <= SPAWN_Y;
      blockX        <= SPAWN_X;
      stored_array  <= '0;
      lines_cleared <= '0;
      scan_row      <= '0;
      spawn_req     <= 1'b0;
      game_over     <= 1'b0;
`ifdef HARD_DROP_EN
      drop_mode     <= 1'b0;
`endif
    end else begin
      state         <= state_next;
      blockY        <= y_next;
      blockX        <= x_next;
      stored_array  <= field_next;
      lines_cleared <= lines_next;
      scan_row      <= scan_row_next;
      spawn_req     <= (state_next == SPAWN);
      game_over     <= (state_next == GAMEOVER);
`ifdef HARD_DROP_EN
      drop_mode     <= drop_mode_next;
`endif
    end
  end

  always_comb begin
    state_next    = state;
    y_next        = blockY;
    x_next        = blockX;
    field_next    = stored_array;
    lines_next    = lines_cleared;
    scan_row_next = scan_row;
`ifdef HARD_DROP_EN
    drop_mode_next = 1'b0;
`endif

    unique case (state)
      IDLE: begin
        if (start) begin
          field_next = '0;
          lines_next = '0;
          state_next = SPAWN;
        end
      end

      SPAWN: begin
        x_next     = SPAWN_X;
        y_next     = SPAWN_Y;
        state_next = SETTLE;
      end

      SETTLE: state_next = FALL;

      FALL: begin
`ifdef HARD_DROP_EN
        // Drop mode owns the piece until it lands; every other input is ignored.
        if (drop_mode || btn_hard) begin
          if (collision_bottom) begin
            state_next = LOCK;
          end else begin
            y_next         = blockY + 5'd1;
            drop_mode_next = 1'b1;
          end
        end else
`endif
        if (descend_c) begin
          if (collision_bottom) state_next = LOCK;
          else                  y_next     = blockY + 5'd1;
        end else if (btn_left && !btn_right && !collision_left) begin
          x_next = blockX - 4'd1;
        end else if (btn_right && !btn_left && !collision_right) begin
          x_next = blockX + 4'd1;
        end
      end

      LOCK: begin
        field_next = stored_array | falling_block_display;
        if (blockY == SPAWN_Y) begin
          state_next = GAMEOVER;
        end else begin
          scan_row_next = ROW_W'(ROWS - 1);
          state_next    = CLEAR;
        end
      end

      // Full rows collapse in place and the same row index is re-examined.
      CLEAR: begin
        if (&stored_array[scan_row]) begin
          field_next = collapse_row(stored_array, scan_row);
          if (lines_cleared != {CNT_W{1'b1}}) lines_next = lines_cleared + 8'd1;
        end else if (scan_row == '0) begin
          state_next = SPAWN;
        end else begin
          scan_row_next = scan_row - 5'd1;
        end
      end

      GAMEOVER: begin
        if (start) begin
          field_next = '0;
          state_next = SPAWN;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_piece_controller.sv
// Directed bench for piece_controller; the hard-drop section runs when
// HARD_DROP_EN is defined for the build.
module tb_piece_controller;
  import tetris_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, tick_drop = 1'b0;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_hard = 1'b0;
  logic coll_bottom_man = 1'b0, floor_en = 1'b0;
  logic collision_bottom, collision_left = 1'b0, collision_right = 1'b0;
  field_t display = '0;
  logic [4:0] blockY;
  logic [3:0] blockX;
  field_t stored_array;
  logic spawn_req, game_over;
  logic [7:0] lines_cleared;

  int n_checks = 0;
  int n_fail   = 0;
  int n;
  field_t disp1, disp2, disp3, exp2;

  // Floor model for the hard-drop case: the piece lands at row 16.
  assign collision_bottom = coll_bottom_man | (floor_en && blockY == 5'd16);

  always #5 clk = ~clk;

  piece_controller dut (
    .clk                   (clk),
    .rst                   (rst),
    .start                 (start),
    .tick_drop             (tick_drop),
    .btn_left              (btn_left),
    .btn_right             (btn_right),
    .btn_down              (btn_down),
    .btn_hard              (btn_hard),
    .collision_bottom      (collision_bottom),
    .collision_left        (collision_left),
    .collision_right       (collision_right),
    .falling_block_display (display),
    .blockY                (blockY),
    .blockX                (blockX),
    .stored_array          (stored_array),
    .spawn_req             (spawn_req),
    .lines_cleared         (lines_cleared),
    .game_over             (game_over)
  );

  task automatic check_eq(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    disp1 = '0; disp1[19] = 10'h3DF; disp1[18] = 10'h3EF; disp1[17] = 10'h300; disp1[10] = 10'h001;
    disp2 = '0; disp2[19] = 10'h020; disp2[18] = 10'h010;
    disp3 = '0; disp3[0]  = 10'h018;
    exp2  = '0; exp2[19]  = 10'h300; exp2[12]  = 10'h001;

    step(); step();
    check_eq("rst_state", 200'(dut.state), 200'(IDLE));
    check_eq("rst_y", 200'(blockY), 200'(5'd0));
    check_eq("rst_x", 200'(blockX), 200'(4'd3));
    check_eq("rst_field", 200'(stored_array), 200'(0));
    check_eq("rst_spawn", 200'(spawn_req), 200'(0));
    check_eq("rst_lines", 200'(lines_cleared), 200'(0));
    check_eq("rst_gameover", 200'(game_over), 200'(0));
    rst = 1'b0;

    start = 1'b1; step(); start = 1'b0;
    check_eq("spawn_state", 200'(dut.state), 200'(SPAWN));
    check_eq("spawn_req_hi", 200'(spawn_req), 200'(1));
    step();
    check_eq("settle_state", 200'(dut.state), 200'(SETTLE));
    check_eq("spawn_req_lo", 200'(spawn_req), 200'(0));
    step();
    check_eq("fall_state", 200'(dut.state), 200'(FALL));
    check_eq("fall_x", 200'(blockX), 200'(4'd3));
    check_eq("fall_y", 200'(blockY), 200'(5'd0));

    tick_drop = 1'b1; btn_left = 1'b1; step(); tick_drop = 1'b0; btn_left = 1'b0;
    check_eq("drop_y", 200'(blockY), 200'(5'd1));
    check_eq("drop_beats_left", 200'(blockX), 200'(4'd3));

    btn_left = 1'b1; btn_right = 1'b1; step(); btn_left = 1'b0; btn_right = 1'b0;
    check_eq("both_lr", 200'(blockX), 200'(4'd3));
    btn_right = 1'b1; collision_right = 1'b1; step(); btn_right = 1'b0; collision_right = 1'b0;
    check_eq("right_blocked", 200'(blockX), 200'(4'd3));
    btn_right = 1'b1; step(); btn_right = 1'b0;
    check_eq("right_move", 200'(blockX), 200'(4'd4));
    btn_left = 1'b1; step(); btn_left = 1'b0;
    check_eq("left_move", 200'(blockX), 200'(4'd3));
    btn_down = 1'b1; step(); btn_down = 1'b0;
    check_eq("down_move", 200'(blockY), 200'(5'd2));

    // First lock builds rows 18/19 with one hole each; nothing clears.
    display = disp1; coll_bottom_man = 1'b1; tick_drop = 1'b1; step();
    coll_bottom_man = 1'b0; tick_drop = 1'b0;
    check_eq("lock1_state", 200'(dut.state), 200'(LOCK));
    check_eq("lock1_y", 200'(blockY), 200'(5'd2));
    step(); display = '0;
    check_eq("lock1_clear", 200'(dut.state), 200'(CLEAR));
    check_eq("lock1_field", 200'(stored_array), 200'(disp1));
    n = 0;
    while (dut.state == CLEAR && n < 100) begin step(); n++; end
    check_eq("clear1_cycles", 200'(n), 200'(20));
    check_eq("clear1_spawn", 200'(spawn_req), 200'(1));
    check_eq("clear1_lines", 200'(lines_cleared), 200'(0));
    step(); step();
    check_eq("respawn_y", 200'(blockY), 200'(5'd0));

    // Second piece plugs both holes: two rows collapse.
    tick_drop = 1'b1; step(); tick_drop = 1'b0;
    display = disp2; coll_bottom_man = 1'b1; tick_drop = 1'b1; step();
    coll_bottom_man = 1'b0; tick_drop = 1'b0;
    step(); display = '0;
    n = 0;
    while (dut.state == CLEAR && n < 100) begin step(); n++; end
    check_eq("clear2_cycles", 200'(n), 200'(22));
    check_eq("clear2_field", 200'(stored_array), 200'(exp2));
    check_eq("clear2_lines", 200'(lines_cleared), 200'(2));
    check_eq("clear2_state", 200'(dut.state), 200'(SPAWN));
    step(); step();

    // Lock at the spawn row ends the game.
    display = disp3; coll_bottom_man = 1'b1; tick_drop = 1'b1; step();
    coll_bottom_man = 1'b0; tick_drop = 1'b0;
    check_eq("go_lock_flag", 200'(game_over), 200'(0));
    step(); display = '0;
    check_eq("go_state", 200'(dut.state), 200'(GAMEOVER));
    check_eq("go_flag", 200'(game_over), 200'(1));
    check_eq("go_field", 200'(stored_array), 200'(exp2 | disp3));
    tick_drop = 1'b1; btn_down = 1'b1; btn_left = 1'b1;
    step(); step(); step();
    tick_drop = 1'b0; btn_down = 1'b0; btn_left = 1'b0;
    check_eq("go_ignore_y", 200'(blockY), 200'(5'd0));
    check_eq("go_ignore_x", 200'(blockX), 200'(4'd3));
    check_eq("go_frozen", 200'(stored_array), 200'(exp2 | disp3));
    start = 1'b1; step(); start = 1'b0;
    check_eq("restart_state", 200'(dut.state), 200'(SPAWN));
    check_eq("restart_field", 200'(stored_array), 200'(0));
    check_eq("restart_spawn", 200'(spawn_req), 200'(1));
    check_eq("restart_flag", 200'(game_over), 200'(0));
    step(); step();

`ifdef HARD_DROP_EN
    floor_en = 1'b1; btn_hard = 1'b1; step(); btn_hard = 1'b0;
    check_eq("hard_first", 200'(blockY), 200'(5'd1));
    btn_left = 1'b1;
    n = 1;
    while (dut.state == FALL && n < 100) begin step(); n++; end
    btn_left = 1'b0;
    check_eq("hard_cycles", 200'(n), 200'(17));
    check_eq("hard_y", 200'(blockY), 200'(5'd16));
    check_eq("hard_x", 200'(blockX), 200'(4'd3));
    check_eq("hard_lock", 200'(dut.state), 200'(LOCK));
    step(); floor_en = 1'b0;
    check_eq("hard_clear", 200'(dut.state), 200'(CLEAR));
`else
    btn_hard = 1'b1; step(); btn_hard = 1'b0;
    check_eq("hard_ignored", 200'(blockY), 200'(5'd0));
    tick_drop = 1'b1; step(); tick_drop = 1'b0;
    coll_bottom_man = 1'b1; tick_drop = 1'b1; step();
    coll_bottom_man = 1'b0; tick_drop = 1'b0;
    step();
    check_eq("pre_rst_clear", 200'(dut.state), 200'(CLEAR));
`endif

    // Reset in the middle of a row scan.
    step(); step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    check_eq("midrst_state", 200'(dut.state), 200'(IDLE));
    check_eq("midrst_lines", 200'(lines_cleared), 200'(0));
    check_eq("midrst_y", 200'(blockY), 200'(5'd0));
    check_eq("midrst_x", 200'(blockX), 200'(4'd3));
    check_eq("midrst_field", 200'(stored_array), 200'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
